// File: rtl/bin_to_bcd_seq_if.sv
// Purpose: start/busy/done handshake bundle between a requester and the BCD converter.
// Latency: none, wires only.
// Backpressure: the requester must watch busy; a start raised while busy is dropped.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  ovf;

  // Requester side: issues operands and observes the result.
  modport master (
    output start, bin,
    input  bcd, busy, done, ovf
  );

  // Converter side.
  modport slave (
    input  start, bin,
    output bcd, busy, done, ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Purpose: sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Latency: WIDTH cycles from the edge that accepts start to the edge that raises done.
// Backpressure: start is honoured only while idle; requests while busy are dropped.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  bin_to_bcd_seq_if.slave bus
);

  // Decimal digits needed to hold the largest WIDTH-bit value.
  function automatic int dec_digits(input int w);
    longint m;
    int     n;
    m = (longint'(1) << w) - 1;
    n = 0;
    while (m > 0) begin
      m = m / 10;
      n = n + 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  localparam int SDIG = dec_digits(WIDTH);
  // Scratch holds the full decimal value, so overflow is just "any digit above DIGITS is nonzero".
  localparam int NDIG = (SDIG > DIGITS) ? SDIG : DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                state_q;
  logic [WIDTH-1:0]      sh_q;
  logic [WIDTH-1:0]      sh_d;
  logic [4*NDIG-1:0]     scr_q;
  logic [4*NDIG-1:0]     scr_add;
  logic [4*NDIG-1:0]     scr_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  last;
  logic                  hi_nz;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [4*DIGITS-1:0]   bcd_d;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift the operand MSB in.
  always_comb begin
    scr_add = scr_q;
    for (int i = 0; i < NDIG; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_add[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    scr_d = (scr_add << 1) | {{(4*NDIG-1){1'b0}}, sh_q[WIDTH-1]};
    sh_d  = sh_q << 1;
    cnt_d = cnt_q + CW'(1);
    last  = (cnt_q == CW'(WIDTH - 1));
  end

  if (NDIG > DIGITS) begin : g_ovf
    assign hi_nz = |scr_d[4*NDIG-1:4*DIGITS];
  end else begin : g_no_ovf
    assign hi_nz = 1'b0;
  end

  // Out-of-range operands saturate to all nines so the display never shows garbage.
  assign bcd_d = hi_nz ? {DIGITS{4'h9}} : scr_d[4*DIGITS-1:0];

  // Control FSM with registered result and handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            sh_q    <= bus.bin;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scr_q <= scr_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_d;
          if (last) begin
            bcd_q   <= bcd_d;
            ovf_q   <= hi_nz;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Purpose: directed self-checking bench for the sequential BCD converter, default and wide variants.
// Latency: expects done exactly WIDTH cycles after the accepting edge.
// Backpressure: exercises starts issued while busy and in the done cycle.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(7),  .DIGITS(2)) ia ();
  bin_to_bcd_seq_if #(.WIDTH(10), .DIGITS(3)) ib ();

  bin_to_bcd_seq #(.WIDTH(7), .DIGITS(2)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ia.slave)
  );

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(3)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ib.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Convert one operand on the 7-bit instance and check latency, result and pulse shape.
  task automatic conv_a(input int v, input logic [7:0] exp_bcd, input logic exp_ovf);
    int n;
    @(posedge clk); #1;
    ia.start = 1'b1;
    ia.bin   = 7'(v);
    @(posedge clk); #1;
    ia.start = 1'b0;
    n = 0;
    while (!ia.done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        chk("a_busy_mid", 32'(ia.busy), 32'd1);
        ia.bin = 7'($urandom);
      end
    end
    chk("a_latency", 32'(n), 32'd7);
    chk("a_bcd", 32'(ia.bcd), 32'(exp_bcd));
    chk("a_ovf", 32'(ia.ovf), 32'(exp_ovf));
    chk("a_busy_done", 32'(ia.busy), 32'd0);
    @(posedge clk); #1;
    chk("a_done_pulse", 32'(ia.done), 32'd0);
    chk("a_bcd_hold", 32'(ia.bcd), 32'(exp_bcd));
  endtask

  // Same for the 10-bit, three-digit instance.
  task automatic conv_b(input int v, input logic [11:0] exp_bcd, input logic exp_ovf);
    int n;
    @(posedge clk); #1;
    ib.start = 1'b1;
    ib.bin   = 10'(v);
    @(posedge clk); #1;
    ib.start = 1'b0;
    n = 0;
    while (!ib.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_latency", 32'(n), 32'd10);
    chk("b_bcd", 32'(ib.bcd), 32'(exp_bcd));
    chk("b_ovf", 32'(ib.ovf), 32'(exp_ovf));
  endtask

  initial begin
    int dcount;
    logic [7:0] ref_bcd;

    ia.start = 1'b0;
    ia.bin   = '0;
    ib.start = 1'b0;
    ib.bin   = '0;
    reset_n  = 1'b0;
    #23;
    chk("reset_a", 32'({ia.bcd, ia.busy, ia.done, ia.ovf}), 32'd0);
    chk("reset_b", 32'({ib.bcd, ib.busy, ib.done, ib.ovf}), 32'd0);
    reset_n = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_a", 32'({ia.bcd, ia.busy, ia.done, ia.ovf}), 32'd0);
    end

    // Basic directed conversions.
    conv_a(0,  8'h00, 1'b0);
    conv_a(9,  8'h09, 1'b0);
    conv_a(10, 8'h10, 1'b0);
    conv_a(59, 8'h59, 1'b0);
    conv_a(99, 8'h99, 1'b0);

    // Overflow saturates, then clears on the next in-range conversion.
    conv_a(100, 8'h99, 1'b1);
    conv_a(127, 8'h99, 1'b1);
    conv_a(42,  8'h42, 1'b0);

    // Exhaustive in-range sweep against tens/units arithmetic.
    for (int v = 0; v < 100; v++) begin
      ref_bcd = {4'(v / 10), 4'(v % 10)};
      conv_a(v, ref_bcd, 1'b0);
    end

    // Starts while busy are ignored; a start in the done cycle is accepted.
    @(posedge clk); #1;
    ia.start = 1'b1;
    ia.bin   = 7'd36;
    @(posedge clk); #1;
    ia.start = 1'b0;
    dcount = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (ia.done) dcount++;
      if (k == 2 || k == 5) begin
        ia.start = 1'b1;
        ia.bin   = 7'd77;
      end
      if (k == 3 || k == 6) ia.start = 1'b0;
    end
    chk("hs_one_done", 32'(dcount), 32'd1);
    chk("hs_done_now", 32'(ia.done), 32'd1);
    chk("hs_first_op", 32'(ia.bcd), 32'h36);
    ia.start = 1'b1;
    ia.bin   = 7'd23;
    @(posedge clk); #1;
    ia.start = 1'b0;
    chk("b2b_busy", 32'(ia.busy), 32'd1);
    chk("b2b_hold", 32'(ia.bcd), 32'h36);
    dcount = 0;
    while (!ia.done && dcount < 40) begin
      @(posedge clk); #1;
      dcount++;
    end
    chk("b2b_latency", 32'(dcount), 32'd7);
    chk("b2b_bcd", 32'(ia.bcd), 32'h23);

    // Reset in the middle of a conversion aborts it.
    @(posedge clk); #1;
    ia.start = 1'b1;
    ia.bin   = 7'd58;
    @(posedge clk); #1;
    ia.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("rst_mid", 32'({ia.bcd, ia.busy, ia.done, ia.ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ia.done || ia.busy) dcount++;
    end
    chk("rst_no_done", 32'(dcount), 32'd0);
    conv_a(58, 8'h58, 1'b0);

    // Wide variant.
    conv_b(999,  12'h999, 1'b0);
    conv_b(512,  12'h512, 1'b0);
    conv_b(1000, 12'h999, 1'b1);
    conv_b(1023, 12'h999, 1'b1);
    conv_b(7,    12'h007, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Produces the packed two-digit BCD value that drives the watch chip's seven-segment decoder for seconds, minutes and hours.
- Replaces wide combinational divide/modulo logic with a small FSM.
- Uses a start/busy/done handshake so the timekeeping logic can request a conversion whenever a counter changes.

Parameters:
- WIDTH, 7, binary input width in bits; range 4..16.
- DIGITS, 2, number of BCD output digits; the output is 4*DIGITS bits wide.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only while idle.
- bin  input  WIDTH  unsigned binary operand; captured on the edge that accepts start.
- bcd  output  4*DIGITS  packed BCD result, least-significant digit in [3:0], tens digit in [7:4].
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd is updated.
- ovf  output  1  high when the last operand exceeded 10^DIGITS-1; valid with done and held until the next done.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, bcd=0, busy=0, done=0, ovf=0.
  - Internal shift register and bit counter cleared.
  - Assertion mid-conversion aborts the conversion immediately; no done pulse follows.
- States: IDLE, SHIFT.
- IDLE:
  - On start=1 at a rising edge: latch bin into the shift register, clear the BCD scratch digits and bit counter, set busy=1, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, one iteration per cycle:
  - Every scratch digit >=5 gets +3 (4-bit add, no carry out of the digit).
  - Then {scratch, shift} shifts left by 1; the operand MSB enters scratch bit 0.
  - The bit counter increments.
  - After exactly WIDTH iterations:
    - bcd <= final scratch (or saturated value), done=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - start sampled at edge E0; iterations at E1..E(WIDTH).
  - bcd, done, ovf update at E(WIDTH); busy is high from after E0 until E(WIDTH).
  - Default: 7 cycles from accept to done.
- Overflow:
  - Scratch register is wide enough to hold the full decimal value of the operand.
  - If the operand exceeds 10^DIGITS-1: ovf=1 and bcd saturates to all-9 digits (default 8'h99).
  - Otherwise ovf=0.
- Start while busy: ignored; the operand is not re-latched and the conversion in flight is unaffected.
- Back-to-back: start high in the same cycle that done is high is accepted, because the FSM is already IDLE. The next done follows WIDTH cycles later. bcd holds the previous result until then.
- bin changing during a conversion: no effect; only the value latched at accept is converted.
- bcd is registered and holds its value between conversions; done is never asserted without a bcd update.
- Every output digit is a legal BCD digit (0..9) under all conditions.

Test Plan:
- Reset release, idle: reset_n low then high with start=0 -> bcd=8'h00, busy=0, done=0, ovf=0 held for 20 cycles.
- Basic conversions: start with bin=0, 9, 10, 59, 99 one at a time -> done exactly 7 cycles after accept, bcd=8'h00, 8'h09, 8'h10, 8'h59, 8'h99 respectively, ovf=0. Also run an exhaustive sweep 0..99 checked against a reference model.
- Overflow: bin=100 and bin=127 -> bcd=8'h99, ovf=1. A following conversion of bin=42 -> bcd=8'h42, ovf=0.
- Handshake: assert start again at cycles 2 and 5 of a conversion with bin changed to 77 -> start ignored, result is the first operand, exactly one done pulse. Then assert start in the done cycle with bin=23 -> accepted, bcd=8'h23 exactly 7 cycles later.
- Reset mid-operation: pull reset_n low at cycle 4 of converting 58 -> busy=0, bcd=8'h00 immediately, no done pulse afterwards. A fresh conversion of 58 after release -> 8'h58.
- Parameter variant: WIDTH=10, DIGITS=3 with bin=999 -> bcd=12'h999, done after 10 cycles. bin=1000 -> bcd=12'h999, ovf=1.
